// File: rtl/native_mem_arbiter.sv
// Two-master round-robin arbiter for one native valid/ready memory port.
// The grant is held for a whole transaction; a timeout force-completes hung ones.
module native_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY0,
    BUSY1
  } state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic                sel;
  logic                w_valid;
  logic                w_instr;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;
  logic                rdy;
  logic [DATA_W-1:0]   rdata;

  // Select the request bundle of the current owner.
  always_comb begin
    sel     = (state_q == BUSY1);
    w_valid = sel ? m1_valid : m0_valid;
    w_instr = sel ? m1_instr : m0_instr;
    w_addr  = sel ? m1_addr  : m0_addr;
    w_wdata = sel ? m1_wdata : m0_wdata;
    w_wstrb = sel ? m1_wstrb : m0_wstrb;
  end

  // Arbitration, forwarding, completion and timeout.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    s_valid     = 1'b0;
    s_instr     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    grant       = 2'b00;
    timeout_err = 1'b0;
    rdy         = 1'b0;
    rdata       = '0;
    case (state_q)
      BUSY0, BUSY1: begin
        grant   = sel ? 2'b10 : 2'b01;
        s_valid = w_valid;
        s_instr = w_instr;
        s_addr  = w_addr;
        s_wdata = w_wdata;
        s_wstrb = w_wstrb;
        if (!w_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_ready) begin
          rdy     = 1'b1;
          rdata   = s_rdata;
          state_d = IDLE;
          ptr_d   = ~sel;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          s_valid     = 1'b0;
          s_wstrb     = '0;
          rdy         = 1'b1;
          rdata       = ERR_RDATA;
          timeout_err = 1'b1;
          state_d     = IDLE;
          ptr_d       = ~sel;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        if (m0_valid && (!m1_valid || !ptr_q))
          state_d = BUSY0;
        else if (m1_valid)
          state_d = BUSY1;
      end
    endcase
    m0_ready = rdy & ~sel;
    m1_ready = rdy & sel;
    m0_rdata = sel ? '0 : rdata;
    m1_rdata = sel ? rdata : '0;
  end

  // State, round-robin pointer and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
